// File: rtl/pc_fetch_sequencer.sv
// Program-counter and run-control stage: start/run/halt handshake plus next-PC selection.
// Optional retired-instruction counter enabled by defining PC_PERF_CNT_EN.
module pc_fetch_sequencer #(
  parameter int unsigned PCW      = 10,
  parameter int unsigned PROG_LEN = 1024,
  parameter int unsigned OFFW     = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic            Stall,
  input  logic            HaltReq,
  input  logic            BranchEn,
  input  logic            BranchRel,
  input  logic [OFFW-1:0] BranchOffset,
  input  logic [PCW-1:0]  BranchTarget,
  output logic [PCW-1:0]  PC,
  output logic            FetchValid,
  output logic            halt,
  output logic            Fault
`ifdef PC_PERF_CNT_EN
  ,
  output logic [15:0]     InstCount
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e         state_q;
  logic [PCW-1:0] pc_q;
  logic           halt_q;
  logic           fault_q;
  logic           start_q;

  logic [PCW-1:0] off_ext;
  logic [PCW-1:0] tgt;
  logic           runoff;
  logic           oob;

  always_comb begin
    off_ext = PCW'($signed(BranchOffset));
    if (BranchEn) begin
      tgt = BranchRel ? (pc_q + off_ext) : BranchTarget;
    end else begin
      tgt = pc_q + PCW'(1);
    end
    // Sequential step off the last word faults even when PROG_LEN == 2^PCW wraps to 0.
    runoff = !BranchEn && (pc_q == PCW'(PROG_LEN - 1));
    oob    = {1'b0, tgt} >= (PCW + 1)'(PROG_LEN);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        StIdle: begin
          pc_q <= '0;
          if (!start && start_q) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!Stall) begin
            if (HaltReq) begin
              state_q <= StHalted;
              halt_q  <= 1'b1;
            end else if (runoff || oob) begin
              state_q <= StHalted;
              halt_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              pc_q <= tgt;
            end
          end
        end
        StHalted: begin
          if (start) begin
            state_q <= StIdle;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          pc_q    <= '0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign FetchValid = (state_q == StRun) && !Stall;
  assign halt       = halt_q;
  assign Fault      = fault_q;

`ifdef PC_PERF_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StHalted && start) begin
      cnt_d = '0;
    end else if (FetchValid && !HaltReq && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign InstCount = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: two instances (PROG_LEN 1024 and 16) driven by shared stimulus and
// compared every cycle against a spec-level reference model; optional counter via PC_PERF_CNT_EN.
module tb_pc_fetch_sequencer;
  localparam int LenA  = 1024;
  localparam int LenB  = 16;
  localparam int PcMod = 1024;
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stall, hreq, ben, brel;
  logic [7:0] off;
  logic [9:0] tgt;
  logic [9:0] pc_a, pc_b;
  logic       fv_a, fv_b, halt_a, halt_b, flt_a, flt_b;
`ifdef PC_PERF_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int checks   = 0;
  int failures = 0;

  int m_st[2], m_pc[2], m_flt[2], m_cnt[2], m_sq[2];
  int lens[2] = '{LenA, LenB};

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.PCW(10), .PROG_LEN(LenA), .OFFW(8)) u_dut_a (
    .CLK(clk), .Reset(rst), .start(start), .Stall(stall), .HaltReq(hreq),
    .BranchEn(ben), .BranchRel(brel), .BranchOffset(off), .BranchTarget(tgt),
    .PC(pc_a), .FetchValid(fv_a), .halt(halt_a), .Fault(flt_a)
`ifdef PC_PERF_CNT_EN
    , .InstCount(cnt_a)
`endif
  );

  pc_fetch_sequencer #(.PCW(10), .PROG_LEN(LenB), .OFFW(8)) u_dut_b (
    .CLK(clk), .Reset(rst), .start(start), .Stall(stall), .HaltReq(hreq),
    .BranchEn(ben), .BranchRel(brel), .BranchOffset(off), .BranchTarget(tgt),
    .PC(pc_b), .FetchValid(fv_b), .halt(halt_b), .Fault(flt_b)
`ifdef PC_PERF_CNT_EN
    , .InstCount(cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = MIdle; m_pc[i] = 0; m_flt[i] = 0; m_cnt[i] = 0; m_sq[i] = 0;
    end
  endtask

  // One rising edge of the spec's run-control rules, in plain integer arithmetic.
  task automatic model_edge();
    int so, t;
    so = $signed(off);
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == MIdle) begin
        m_pc[i] = 0;
        if (!start && m_sq[i] != 0) m_st[i] = MRun;
      end else if (m_st[i] == MRun) begin
        if (!stall) begin
          if (hreq) begin
            m_st[i] = MHalt;
          end else begin
            if (m_cnt[i] < 65535) m_cnt[i]++;
            if (ben) t = brel ? (((m_pc[i] + so) % PcMod) + PcMod) % PcMod : int'(tgt);
            else     t = (m_pc[i] + 1) % PcMod;
            if ((!ben && m_pc[i] == lens[i] - 1) || t >= lens[i]) begin
              m_st[i] = MHalt; m_flt[i] = 1;
            end else begin
              m_pc[i] = t;
            end
          end
        end
      end else if (start) begin
        m_st[i] = MIdle; m_pc[i] = 0; m_flt[i] = 0; m_cnt[i] = 0;
      end
      m_sq[i] = start ? 1 : 0;
    end
  endtask

  task automatic check_all();
    chk("a_pc", 32'(pc_a), m_pc[0]);
    chk("a_fv", 32'(fv_a), (m_st[0] == MRun && !stall) ? 1 : 0);
    chk("a_halt", 32'(halt_a), (m_st[0] == MHalt) ? 1 : 0);
    chk("a_fault", 32'(flt_a), m_flt[0]);
    chk("b_pc", 32'(pc_b), m_pc[1]);
    chk("b_fv", 32'(fv_b), (m_st[1] == MRun && !stall) ? 1 : 0);
    chk("b_halt", 32'(halt_b), (m_st[1] == MHalt) ? 1 : 0);
    chk("b_fault", 32'(flt_b), m_flt[1]);
`ifdef PC_PERF_CNT_EN
    chk("a_cnt", 32'(cnt_a), m_cnt[0]);
    chk("b_cnt", 32'(cnt_b), m_cnt[1]);
`endif
  endtask

  task automatic cyc(input logic s, input logic sl, input logic h, input logic be,
                     input logic br, input logic [7:0] o, input logic [9:0] tg);
    start = s; stall = sl; hreq = h; ben = be; brel = br; off = o; tgt = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);
  endtask

  // Reset pulse placed between clock edges; outputs must react before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_pc_async", 32'(pc_a), 0);
    chk("rst_halt_async", 32'(halt_a), 0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stall = 0; hreq = 0; ben = 0; brel = 0; off = '0; tgt = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_pc", 32'(pc_a), 0);
    #1 rst = 1'b0;

    // start held low never launches
    idle(2);
    chk("no_launch_fv", 32'(fv_a), 0);

    // launch on falling start
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    chk("idle_fv", 32'(fv_a), 0);
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    cyc(0, 0, 0, 0, 0, 8'd0, 10'd0);
    chk("launch_pc0", 32'(pc_a), 0);
    chk("launch_fv", 32'(fv_a), 1);
    idle(1); chk("launch_pc1", 32'(pc_a), 1);
    idle(1); chk("launch_pc2", 32'(pc_a), 2);
    idle(1); chk("launch_pc3", 32'(pc_a), 3);
    idle(2); chk("at_pc5", 32'(pc_a), 5);

    // relative -3, then absolute 40 (out of range for the 16-word instance)
    cyc(0, 0, 0, 1, 1, 8'hFD, 10'd0);
    chk("rel_branch", 32'(pc_a), 2);
    cyc(0, 0, 0, 1, 0, 8'd0, 10'd40);
    chk("abs_jump", 32'(pc_a), 40);
    chk("b_oob_fault", 32'(flt_b), 1);
    chk("b_oob_pc_held", 32'(pc_b), 2);

    // start during RUN ignored; B restarts
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    chk("start_in_run", 32'(pc_a), 41);
    chk("b_restart_fault_clr", 32'(flt_b), 0);
    cyc(0, 0, 0, 1, 0, 8'd0, 10'd7);
    chk("jump_7", 32'(pc_a), 7);

    // stall overrides halt and branch
    repeat (3) begin
      cyc(0, 1, 1, 1, 0, 8'd0, 10'd20);
      chk("stall_pc", 32'(pc_a), 7);
      chk("stall_fv", 32'(fv_a), 0);
      chk("stall_halt", 32'(halt_a), 0);
    end
    idle(1);
    chk("post_stall_pc", 32'(pc_a), 8);

    // halt at 12, then restart
    idle(4);
    cyc(0, 0, 1, 0, 0, 8'd0, 10'd0);
    chk("halt_flag", 32'(halt_a), 1);
    chk("halt_pc", 32'(pc_a), 12);
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    chk("restart_pc", 32'(pc_a), 0);
    chk("restart_halt", 32'(halt_a), 0);
    cyc(0, 0, 0, 0, 0, 8'd0, 10'd0);
    chk("relaunch_fv", 32'(fv_a), 1);

    // runoff on the 16-word instance
    idle(15);
    chk("b_at_15", 32'(pc_b), 15);
    idle(1);
    chk("b_runoff_fault", 32'(flt_b), 1);
    chk("b_runoff_halt", 32'(halt_b), 1);
    chk("b_runoff_pc", 32'(pc_b), 15);
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    cyc(0, 0, 0, 0, 0, 8'd0, 10'd0);
    cyc(0, 0, 0, 1, 0, 8'd0, 10'd20);
    chk("b_target20_fault", 32'(flt_b), 1);
    chk("b_target20_pc", 32'(pc_b), 0);
    chk("a_target20", 32'(pc_a), 20);

    // async reset in RUN at PC 9
    cyc(0, 0, 0, 1, 0, 8'd0, 10'd9);
    chk("at_pc9", 32'(pc_a), 9);
    async_reset();

    // 12 instructions then halt
    cyc(1, 0, 0, 0, 0, 8'd0, 10'd0);
    cyc(0, 0, 0, 0, 0, 8'd0, 10'd0);
    idle(12);
    cyc(0, 0, 1, 0, 0, 8'd0, 10'd0);
    chk("count_halt", 32'(halt_a), 1);
`ifdef PC_PERF_CNT_EN
    chk("inst_count_12", 32'(cnt_a), 12);
`endif

    // randomized phase
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 33) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 1), 8'($urandom), 10'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter and run-control stage; sits directly upstream of the instruction ROM and decode/ALU path inside TopLevel.
- Owns the start/run/halt handshake that the top-level bench drives through `start` and observes through `halt`.
- Produces the fetch address every cycle and applies next-PC selection: sequential, relative branch, absolute jump, stall hold and halt.

Parameters:
- PCW, 10, PC width in bits; all PC arithmetic is modulo 2^PCW.
- PROG_LEN, 1024, number of valid instruction words; legal PC range is 0..PROG_LEN-1 (PROG_LEN <= 2^PCW).
- OFFW, 8, width of the signed relative branch offset.

Ports:
- CLK  in  1  system clock, rising-edge active.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  launch control: hold high, then drop low to begin execution.
- Stall  in  1  freeze the PC this cycle (downstream not ready).
- HaltReq  in  1  decoded halt instruction at current PC.
- BranchEn  in  1  take a branch/jump this cycle.
- BranchRel  in  1  1 = relative (PC + sext(BranchOffset)); 0 = absolute (BranchTarget).
- BranchOffset  in  OFFW  signed two's-complement offset.
- BranchTarget  in  PCW  absolute jump target.
- PC  out  PCW  current fetch address to the instruction ROM.
- FetchValid  out  1  PC holds a live instruction to execute this cycle.
- halt  out  1  done flag.
- Fault  out  1  sticky flag: runoff past PROG_LEN-1 or out-of-range target.

Behaviour:
- Reset:
  - Asynchronous, active-high, takes effect at any time, including mid-RUN.
  - Forces state IDLE, PC=0, halt=0, Fault=0, start_q=0.
- States: IDLE, RUN, HALTED. The block keeps a registered copy of start, called start_q.
- IDLE:
  - PC is held at 0; FetchValid=0; halt=0.
  - Goes to RUN on the first rising edge where start==0 and start_q==1 (falling edge of start).
  - start held low from reset never launches.
- RUN: FetchValid = ~Stall (combinational). Next-PC priority, evaluated at each rising edge:
  - 1. Stall=1: PC holds; HaltReq, BranchEn and BranchRel are ignored.
  - 2. HaltReq=1: go to HALTED; PC holds; halt=1 from the following cycle.
  - 3. BranchEn=1 and BranchRel=1: compute t = PC + sign-extended BranchOffset, modulo 2^PCW.
  - 4. BranchEn=1 and BranchRel=0: t = BranchTarget.
  - 5. Otherwise: t = PC + 1.
  - For cases 3-5: if t <= PROG_LEN-1, PC <= t.
  - If t >= PROG_LEN, or a sequential increment occurs from PC == PROG_LEN-1: go to HALTED, set Fault=1, and hold PC at its pre-transition value.
- HALTED:
  - halt=1; FetchValid=0; PC holds its value.
  - On start==1: go to IDLE with PC=0, halt=0 and Fault=0 (restart path). Reset is not required.
- Output timing:
  - halt and Fault are registered (high one cycle after the triggering edge).
  - PC is registered.
  - FetchValid is combinational from state and Stall.
- Start during RUN:
  - start rising to 1 in RUN is ignored. Only Reset or halt ends a run.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- With the macro defined:
  - Adds output InstCount (16 bits).
  - Counts RUN cycles with FetchValid=1 where HaltReq=0, i.e. retired non-halt instructions.
  - Saturates at 16'hFFFF.
  - Cleared by Reset and on the HALTED->IDLE restart.
  - Holds its value in HALTED.
- Without the macro: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Launch sequencing:
  - Stimulus: Reset pulse; start=1 for 2 cycles, then 0.
  - Required: PC=0 and FetchValid=0 in IDLE; RUN entered on the edge after start falls; PC = 1, 2, 3 on successive edges; halt=0.
- Branches:
  - Stimulus: relative branch at PC=5 with BranchOffset=8'hFD (-3), then absolute BranchTarget=40.
  - Required: PC becomes 2, then 40.
- Stall priority:
  - Stimulus: Stall=1 for 3 cycles at PC=7, with HaltReq=1 and BranchEn=1 asserted during the stall; then Stall=0 with HaltReq=0.
  - Required: PC stays 7 and FetchValid=0 during the stall; PC becomes 8 afterwards; halt stays 0.
- Halt then restart:
  - Stimulus: HaltReq=1 at PC=12; then start=1, then start=0.
  - Required: halt=1 the next cycle with PC=12 held; start=1 gives IDLE with PC=0 and halt=0; start falling relaunches from PC=0.
- Fault cases (PROG_LEN=16):
  - Stimulus A: sequential execution reaching PC=15.
  - Required A: next edge gives HALTED, Fault=1, halt=1, PC=15.
  - Stimulus B: absolute jump with BranchTarget=20.
  - Required B: Fault=1 and PC is unchanged.
- Reset and counter:
  - Stimulus: assert Reset asynchronously between clock edges while in RUN at PC=9.
  - Required: PC=0, IDLE state and halt=0 immediately, without waiting for a clock edge.
  - With PC_PERF_CNT_EN: InstCount=0 after the reset, and InstCount=12 after a run of 12 instructions followed by a halt.
